crc_link_deserializer: RTL and testbench
========================================

Name: crc_link_deserializer

Overview:
- Serial-to-parallel front end that sits directly upstream of the CRC receiver.
- Recovers framed 15-bit codewords from a bit-strobed serial line and checks frame structure and link parity.
- Presents good words to the receiver's data_re input through a valid/ready handshake.
- Counts link-level errors so CRC-level errors can be told apart from framing faults.

Parameters:
- DATA_W, 15, codeword width; must match receiver data_re width.
- MSB_FIRST, 1, 1 = first serial data bit lands in word_out[DATA_W-1]; 0 = first bit lands in word_out[0].
- ERR_CNT_W, 8, width of the saturating link error counter.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- bit_valid  in  1  one-cycle strobe; serial_in is sampled only when high.
- serial_in  in  1  serial line; idles at 1.
- word_ready  in  1  downstream (receiver) accepts word_out.
- word_out  out  DATA_W  assembled codeword, goes to receiver data_re.
- word_valid  out  1  word_out holds an unconsumed good word.
- parity_err  out  1  one-cycle pulse: frame had a bad even-parity bit.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: good frame dropped because word_valid was still high with word_ready low.
- err_count  out  ERR_CNT_W  saturating count of parity_err + frame_err + overrun events.

Behaviour:
- Frame format on successive bit_valid samples:
  - start bit 0;
  - DATA_W data bits;
  - 1 parity bit (even parity over data + parity);
  - stop bit 1.
- Reset (reset==0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0;
  - word_out=0, word_valid=0, parity_err=0, frame_err=0, overrun=0, err_count=0.
- FSM advances only on cycles with bit_valid=1; otherwise it holds.
  - IDLE: serial_in==0 -> DATA, counter=0. serial_in==1 -> stay.
  - DATA: shift serial_in into the shift register per MSB_FIRST and increment counter. On the DATA_W-th bit -> PARITY.
  - PARITY: store the parity bit and compute par_ok = ~^(shift, bit) -> STOP.
  - STOP, serial_in==0: frame_err pulse, frame discarded. frame_err takes priority over a parity fault.
  - STOP, serial_in==1 and !par_ok: parity_err pulse, frame discarded.
  - STOP, serial_in==1 and par_ok: deliver word. All STOP outcomes -> IDLE.
- Delivery happens on the clock edge that samples the stop bit (1-cycle latency from the stop strobe):
  - if word_valid==0, or word_valid==1 with word_ready==1 in the same cycle: word_out<=shift, word_valid<=1;
  - else the new word is dropped, word_out is unchanged and overrun pulses.
- Handshake:
  - transfer occurs when word_valid && word_ready;
  - word_valid clears the following edge unless a new delivery happens in the same cycle, in which case it stays 1 with new data;
  - word_out is stable while word_valid=1 and word_ready=0.
- Error pulses last exactly one cycle. At most one error type per frame.
- err_count increments by 1 per error pulse and saturates at 2^ERR_CNT_W-1 (no wrap).
- A start bit is only recognised in IDLE. A 0 sampled in STOP is a frame error, not a new start.
- Reset mid-frame aborts the frame with no error pulse. The bit stream after reset release needs a fresh start bit.
- word_ready is ignored while word_valid=0.

Test Plan:
- Send frame start 0, data 15'b111010011010000 MSB first, parity 1, stop 1, word_ready=1 -> word_valid=1 one cycle after the stop strobe; word_out=15'b111010011010000; no error pulses; err_count=0.
- Same data with parity bit 0 -> parity_err pulses 1 cycle; word_valid stays 0; err_count=1.
- Data 15'b111010011011100, parity 1, stop bit 0 -> frame_err pulses; parity_err=0; no word; err_count increments by 1.
- word_ready=0; send two good frames (15'b111010011010000 then 15'b111010011011100) -> first word held in word_out; overrun pulses at the second stop; word_out unchanged; assert word_ready -> transfer of the first word, then word_valid=0.
- word_valid=1 and word_ready=1 on the same cycle a new stop completes -> word_valid stays 1; word_out=new word; no overrun.
- Assert reset (0) after 7 data bits, release, then send a full good frame -> all outputs 0 during reset; only the second frame is delivered; no error pulses. Also force 300 frame errors with ERR_CNT_W=8 -> err_count saturates at 255.

Source files
------------

// File: rtl/crc_link_deserializer.sv
// Serial-to-parallel front end for the CRC receiver.
// Recovers framed codewords (start, DATA_W data bits, even parity, stop) from a
// bit-strobed serial line, delivers good words over valid/ready, and counts
// link-level faults separately from anything the CRC stage later finds.
module crc_link_deserializer #(
    parameter int DATA_W    = 15,
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_valid,
    input  logic                 serial_in,
    input  logic                 word_ready,
    output logic [DATA_W-1:0]    word_out,
    output logic                 word_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_q;
    logic [DATA_W-1:0]   shift_nxt;
    logic                par_ok;

    // Frame outcomes, valid only on the cycle the stop bit is sampled.
    logic                stop_bad;
    logic                par_bad;
    logic                frame_good;
    logic                xfer;
    logic                load;
    logic                drop;
    logic                err_event;

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and stop-bit classification; advances only on bit strobes.
    // NOTE: every signal gets a default first so no path through the block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        stop_bad   = 1'b0;
        par_bad    = 1'b0;
        frame_good = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE:    if (!serial_in) state_nxt = DATA;
                DATA:    if (bit_cnt == LAST_BIT) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    // A 0 here is a broken frame, never a new start bit.
                    state_nxt = IDLE;
                    if (!serial_in)  stop_bad   = 1'b1;
                    else if (!par_ok) par_bad   = 1'b1;
                    else             frame_good = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shift direction decides which word bit the first serial data bit lands in.
    always_comb begin
        if (MSB_FIRST) shift_nxt = {shift_q[DATA_W-2:0], serial_in};
        else           shift_nxt = {serial_in, shift_q[DATA_W-1:1]};
    end

    // Bit counter, shift register and parity verdict for the frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shift_q <= '0;
            par_ok  <= 1'b0;
        end else if (bit_valid) begin
            case (state)
                IDLE: if (!serial_in) bit_cnt <= '0;
                DATA: begin
                    shift_q <= shift_nxt;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                PARITY:  par_ok <= ~^{shift_q, serial_in};
                default: ;
            endcase
        end
    end

    // A good frame lands only if the output slot is empty or being drained now.
    assign xfer      = word_valid && word_ready;
    assign load      = frame_good && (!word_valid || word_ready);
    assign drop      = frame_good && !load;
    assign err_event = stop_bad || par_bad || drop;

    // Output word register, one-cycle error pulses and saturating error count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            err_count  <= '0;
        end else begin
            parity_err <= par_bad;
            frame_err  <= stop_bad;
            overrun    <= drop;
            if (load) begin
                word_out   <= shift_q;
                word_valid <= 1'b1;
            end else if (xfer) begin
                word_valid <= 1'b0;
            end
            if (err_event && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_crc_link_deserializer.sv
// Self-checking bench for crc_link_deserializer: directed frames plus random
// traffic, compared every cycle against a frame-level reference model.
module tb_crc_link_deserializer;

    localparam int DATA_W    = 15;
    localparam int ERR_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;

    localparam logic [DATA_W-1:0] D1 = 15'b111010011010000;
    localparam logic [DATA_W-1:0] D2 = 15'b111010011011100;

    typedef enum int {EV_NONE, EV_GOOD, EV_PERR, EV_FERR} ev_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 bit_valid;
    logic                 serial_in;
    logic                 word_ready;
    logic [DATA_W-1:0]    word_out;
    logic                 word_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic [ERR_CNT_W-1:0] err_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic              exp_valid;
    logic [DATA_W-1:0] exp_word;
    int                exp_cnt;
    logic              exp_perr;
    logic              exp_ferr;
    logic              exp_ovr;

    // 0: ready low, 1: ready high, 2: random, 3: high only on the stop strobe.
    int rdy_mode;

    crc_link_deserializer #(
        .DATA_W   (DATA_W),
        .MSB_FIRST(1'b1),
        .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .serial_in (serial_in),
        .word_ready(word_ready),
        .word_out  (word_out),
        .word_valid(word_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where);
        check({where, "/word_valid"}, 32'(word_valid), 32'(exp_valid));
        check({where, "/word_out"},   32'(word_out),   32'(exp_word));
        check({where, "/parity_err"}, 32'(parity_err), 32'(exp_perr));
        check({where, "/frame_err"},  32'(frame_err),  32'(exp_ferr));
        check({where, "/overrun"},    32'(overrun),    32'(exp_ovr));
        check({where, "/err_count"},  32'(err_count),  32'(exp_cnt));
    endtask

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_word  = '0;
        exp_cnt   = 0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
    endtask

    function automatic logic pick_rdy(input bit is_stop);
        case (rdy_mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return logic'($urandom_range(1, 0));
            default: return is_stop;
        endcase
    endfunction

    // One clock cycle: drive at the negedge, update the model at the posedge,
    // compare at the following negedge. ev describes what this edge completes.
    task automatic step(input logic bv, input logic sin, input logic rdy,
                        input ev_t ev, input logic [DATA_W-1:0] w);
        logic xfer;
        bit_valid  = bv;
        serial_in  = sin;
        word_ready = rdy;
        @(posedge clk);
        xfer     = exp_valid && rdy;
        exp_perr = (ev == EV_PERR);
        exp_ferr = (ev == EV_FERR);
        exp_ovr  = 1'b0;
        if (ev == EV_GOOD && (!exp_valid || rdy)) begin
            exp_word  = w;
            exp_valid = 1'b1;
        end else begin
            if (ev == EV_GOOD) exp_ovr = 1'b1;
            if (xfer) exp_valid = 1'b0;
        end
        if ((exp_perr || exp_ferr || exp_ovr) && exp_cnt < CNT_MAX) exp_cnt++;
        @(negedge clk);
        check_outputs("cyc");
    endtask

    // Sends one frame with optional random idle gaps; the outcome is decided
    // from the frame contents alone.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input logic stp, input int gap_max);
        ev_t  ev;
        logic bits [DATA_W+3];
        ev = !stp ? EV_FERR : ((^data ^ par) ? EV_PERR : EV_GOOD);
        bits[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) bits[1+i] = data[DATA_W-1-i];
        bits[DATA_W+1] = par;
        bits[DATA_W+2] = stp;
        for (int i = 0; i < DATA_W + 3; i++) begin
            repeat ($urandom_range(gap_max, 0))
                step(1'b0, logic'($urandom_range(1, 0)), pick_rdy(1'b0), EV_NONE, '0);
            if (i == DATA_W + 2) step(1'b1, bits[i], pick_rdy(1'b1), ev, data);
            else                 step(1'b1, bits[i], pick_rdy(1'b0), EV_NONE, '0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] rnd;
        reset      = 1'b0;
        bit_valid  = 1'b0;
        serial_in  = 1'b1;
        word_ready = 1'b0;
        rdy_mode   = 1;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check_outputs("reset");
        reset = 1'b1;

        // Good frame, ready high.
        send_frame(D1, 1'b1, 1'b1, 0);
        check("t1_word",  32'(word_out),   32'(D1));
        check("t1_valid", 32'(word_valid), 32'd1);
        check("t1_cnt",   32'(err_count),  32'd0);

        // Bad parity.
        send_frame(D1, 1'b0, 1'b1, 1);
        check("t2_cnt", 32'(err_count), 32'd1);

        // Bad stop bit wins over parity.
        send_frame(D2, 1'b1, 1'b0, 1);
        check("t3_cnt", 32'(err_count), 32'd2);

        // Two good frames with ready low: second one overruns.
        rdy_mode = 0;
        send_frame(D1, 1'b1, 1'b1, 1);
        send_frame(D2, 1'b1, 1'b1, 1);
        check("t4_word", 32'(word_out),  32'(D1));
        check("t4_cnt",  32'(err_count), 32'd3);
        step(1'b0, 1'b1, 1'b1, EV_NONE, '0);
        check("t4_drained", 32'(word_valid), 32'd0);

        // Delivery in the same cycle as a transfer keeps valid with new data.
        send_frame(D1, 1'b1, 1'b1, 0);
        rdy_mode = 3;
        send_frame(D2, 1'b1, 1'b1, 0);
        check("t5_word",  32'(word_out),   32'(D2));
        check("t5_valid", 32'(word_valid), 32'd1);
        check("t5_cnt",   32'(err_count),  32'd3);
        step(1'b0, 1'b1, 1'b1, EV_NONE, '0);

        // Reset after 7 data bits, then a fresh good frame.
        rdy_mode = 1;
        step(1'b1, 1'b0, 1'b1, EV_NONE, '0);
        for (int i = 0; i < 7; i++) step(1'b1, D2[DATA_W-1-i], 1'b1, EV_NONE, '0);
        #2 reset = 1'b0;
        model_reset();
        #1 check_outputs("mid_reset");
        repeat (2) @(negedge clk);
        check_outputs("held_reset");
        reset = 1'b1;
        send_frame(D1, 1'b1, 1'b1, 0);
        check("t6_word", 32'(word_out),  32'(D1));
        check("t6_cnt",  32'(err_count), 32'd0);

        // Random traffic.
        rdy_mode = 2;
        for (int f = 0; f < 150; f++) begin
            rnd = DATA_W'($urandom);
            send_frame(rnd,
                       ($urandom_range(3, 0) == 0) ? ~(^rnd) : ^rnd,
                       ($urandom_range(6, 0) != 0),
                       2);
        end

        // Saturation of the error counter.
        rdy_mode = 1;
        for (int f = 0; f < 300; f++) send_frame(D2, 1'b1, 1'b0, 0);
        check("sat_cnt", 32'(err_count), 32'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
